mem_ctrl_arbiter: RTL and testbench
===================================

MEM_CTRL_ARBITER -- requirements
Module: mem_ctrl_arbiter

Interface
REQ-001 SHALL have parameter FIXED_DCACHE_PRIO, default 0; 0 selects round-robin arbitration, 1 makes dcache always win ties.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_aH  in  1  synchronous, active-high reset.
REQ-005 icache_req_valid / icache_req_ready  in/out  1/1  icache read-request handshake.
REQ-006 icache_req_block_addr  in  main_mem_block_addr_t  icache block address; icache requests are always reads.
REQ-007 icache_resp_valid / icache_resp_block_data  out  1 / block_data_t  icache fill response.
REQ-008 dcache_req_valid / dcache_req_ready  in/out  1/1  dcache request handshake.
REQ-009 dcache_req_type  in  req_type_t  0 = read, 1 = write.
REQ-010 dcache_req_block_addr / dcache_req_block_data  in  main_mem_block_addr_t / block_data_t  dcache address and write data.
REQ-011 dcache_resp_valid / dcache_resp_block_data  out  1 / block_data_t  dcache read response.
REQ-012 mem_req_valid / mem_req_ready  out/in  1/1  main-memory request handshake.
REQ-013 mem_req_type / mem_req_block_addr / mem_req_block_data  out  req_type_t / main_mem_block_addr_t / block_data_t  forwarded request.
REQ-014 mem_resp_valid / mem_resp_block_data  in  1 / block_data_t  main-memory read response.
REQ-015 spurious_resp_err  out  1  sticky flag: mem_resp_valid was seen outside WAIT_RESP.

Function
REQ-016 SHALL allow at most one outstanding main-memory transaction.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_RESP.
REQ-018 IDLE: if any requester is valid, grant exactly one; assert its req_ready combinationally in that cycle; latch owner, type, addr and data; go to ISSUE. The non-granted ready stays 0.
REQ-019 Arbitration when both are valid: with FIXED_DCACHE_PRIO=0, grant the port not granted last (last_grant register); with FIXED_DCACHE_PRIO=1, grant dcache.
REQ-020 last_grant SHALL update only on a grant.
REQ-021 ISSUE: mem_req_valid=1 and driven from latched registers, held stable until mem_req_ready. On handshake: write -> IDLE (no response forwarded); read -> WAIT_RESP.
REQ-022 WAIT_RESP: on mem_resp_valid, assert the owner's resp_valid for exactly that cycle, passing mem_resp_block_data combinationally; next state IDLE.
REQ-023 Both resp_block_data outputs SHALL carry mem_resp_block_data at all times; only resp_valid is steered.
REQ-024 req_ready SHALL be 0 in ISSUE and WAIT_RESP, so a new grant is possible no earlier than the cycle after the response or write acceptance.
REQ-025 Minimum read latency: grant at cycle N -> mem_req_valid at N+1 -> response forwarded on the same cycle as mem_resp_valid.
REQ-026 Each requester's valid is treated as persistent; a request dropped before grant SHALL be ignored without error.
REQ-027 mem_resp_valid in IDLE or ISSUE SHALL be dropped and SHALL set spurious_resp_err; the flag clears only on reset.
REQ-028 mem_req_ready while not in ISSUE SHALL be ignored.

Reset
REQ-029 rst_aH SHALL force state=IDLE, last_grant=dcache (so icache wins the first tie), latched registers=0 and spurious_resp_err=0.
REQ-030 During reset, every valid/ready output SHALL be 0.
REQ-031 Reset asserted in ISSUE or WAIT_RESP SHALL abandon the transaction silently; a late mem_resp_valid arriving in IDLE afterwards sets spurious_resp_err.

Structure
REQ-032 req_type_t, main_mem_block_addr_t and block_data_t SHALL come from the shared global definitions; the FSM state enum and the owner encoding stay local to the module.
REQ-033 SHALL be a single module with no sub-modules; the 2-way round-robin arbiter is inline logic.

Verification
REQ-034 Bench SHALL cover, with FIXED_DCACHE_PRIO=0:
- Post-reset tie: both valid, icache addr 0x10, dcache read 0x20 -> icache granted first; mem sees 0x10, then 0x20 after the icache response.
- Back-to-back ties: three consecutive ties -> grants alternate icache, dcache, icache.
- dcache write: addr 0x5, data 0xA5A5; mem_req_ready held low 3 cycles -> request stable all 3 cycles; IDLE the cycle after accept; no resp_valid on either port.
- Read steering: dcache read, response data 0xDEAD -> dcache_resp_valid=1 for one cycle with 0xDEAD; icache_resp_valid stays 0.
- Spurious response: mem_resp_valid in IDLE -> spurious_resp_err=1 and held until rst_aH.
- Mid-transaction reset: rst_aH in WAIT_RESP -> all outputs 0; next request is granted normally.
REQ-035 Bench SHALL cover, with FIXED_DCACHE_PRIO=1: repeated ties -> dcache always granted.

Source files
------------

// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared memory-side type definitions used by the cache/memory path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: block address and block data widths, request type encoding.
package mem_ctrl_arbiter_pkg;

    localparam int MAIN_MEM_ADDR_W = 26;
    localparam int BLOCK_DATA_W    = 128;

    typedef logic [MAIN_MEM_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_W-1:0]    block_data_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates icache and dcache block requests onto one main-memory port, one transaction in flight.
// Latency: grant cycle N, mem_req_valid at N+1, read response forwarded combinationally with mem_resp_valid.
// Backpressure: req_ready only in IDLE on the granted port; mem request held stable until mem_req_ready.
//
// Ports:
//   clk, rst_aH                          - clock, synchronous active-high reset
//   icache_req_* / icache_resp_*         - icache read requests and fill responses
//   dcache_req_* / dcache_resp_*         - dcache read/write requests and read responses
//   mem_req_* / mem_resp_*               - main-memory request and response
//   spurious_resp_err                    - sticky: memory response seen while no read was outstanding
module mem_ctrl_arbiter
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter bit FIXED_DCACHE_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_aH,

    input  logic                 icache_req_valid,
    output logic                 icache_req_ready,
    input  main_mem_block_addr_t icache_req_block_addr,
    output logic                 icache_resp_valid,
    output block_data_t          icache_resp_block_data,

    input  logic                 dcache_req_valid,
    output logic                 dcache_req_ready,
    input  req_type_t            dcache_req_type,
    input  main_mem_block_addr_t dcache_req_block_addr,
    input  block_data_t          dcache_req_block_data,
    output logic                 dcache_resp_valid,
    output block_data_t          dcache_resp_block_data,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output req_type_t            mem_req_type,
    output main_mem_block_addr_t mem_req_block_addr,
    output block_data_t          mem_req_block_data,
    input  logic                 mem_resp_valid,
    input  block_data_t          mem_resp_block_data,

    output logic                 spurious_resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } owner_t;

    state_t               state_q, state_d;
    owner_t               last_grant_q;
    owner_t               owner_q;
    owner_t               grant_sel;
    req_type_t            type_q;
    main_mem_block_addr_t addr_q;
    block_data_t          data_q;
    logic                 spurious_q;
    logic                 grant_any;

    // Two-way arbiter: on a tie, either dcache wins outright or the port
    // that lost the previous grant wins.
    always_comb begin
        grant_any = icache_req_valid | dcache_req_valid;
        grant_sel = OWN_ICACHE;
        if (icache_req_valid && dcache_req_valid) begin
            if (FIXED_DCACHE_PRIO)
                grant_sel = OWN_DCACHE;
            else
                grant_sel = (last_grant_q == OWN_DCACHE) ? OWN_ICACHE : OWN_DCACHE;
        end else if (dcache_req_valid) begin
            grant_sel = OWN_DCACHE;
        end
    end

    // Next state and handshake outputs. Everything stays low while reset is
    // asserted so an abandoned transaction never leaks a valid or ready.
    always_comb begin
        state_d           = state_q;
        icache_req_ready  = 1'b0;
        dcache_req_ready  = 1'b0;
        mem_req_valid     = 1'b0;
        icache_resp_valid = 1'b0;
        dcache_resp_valid = 1'b0;
        if (!rst_aH) begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        state_d          = ST_ISSUE;
                        icache_req_ready = (grant_sel == OWN_ICACHE);
                        dcache_req_ready = (grant_sel == OWN_DCACHE);
                    end
                end
                ST_ISSUE: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready)
                        state_d = (type_q == REQ_WRITE) ? ST_IDLE : ST_WAIT_RESP;
                end
                ST_WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        state_d           = ST_IDLE;
                        icache_resp_valid = (owner_q == OWN_ICACHE);
                        dcache_resp_valid = (owner_q == OWN_DCACHE);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_aH) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWN_DCACHE;
            owner_q      <= OWN_ICACHE;
            type_q       <= REQ_READ;
            addr_q       <= '0;
            data_q       <= '0;
            spurious_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && grant_any) begin
                owner_q      <= grant_sel;
                last_grant_q <= grant_sel;
                if (grant_sel == OWN_DCACHE) begin
                    type_q <= dcache_req_type;
                    addr_q <= dcache_req_block_addr;
                    data_q <= dcache_req_block_data;
                end else begin
                    type_q <= REQ_READ;
                    addr_q <= icache_req_block_addr;
                    data_q <= '0;
                end
            end
            // A response with no read outstanding is dropped but remembered.
            if (mem_resp_valid && state_q != ST_WAIT_RESP)
                spurious_q <= 1'b1;
        end
    end

    assign mem_req_type       = type_q;
    assign mem_req_block_addr = addr_q;
    assign mem_req_block_data = data_q;

    // Response data is broadcast; only the valid is steered to the owner.
    assign icache_resp_block_data = mem_resp_block_data;
    assign dcache_resp_block_data = mem_resp_block_data;

    assign spurious_resp_err = spurious_q;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Testbench for mem_ctrl_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; a second instance covers fixed dcache priority.
module tb_mem_ctrl_arbiter;
    import mem_ctrl_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_aH;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic icache_req_valid, icache_req_ready, icache_resp_valid;
    main_mem_block_addr_t icache_req_block_addr;
    block_data_t icache_resp_block_data;
    logic dcache_req_valid, dcache_req_ready, dcache_resp_valid;
    req_type_t dcache_req_type;
    main_mem_block_addr_t dcache_req_block_addr;
    block_data_t dcache_req_block_data, dcache_resp_block_data;
    logic mem_req_valid, mem_req_ready, mem_resp_valid;
    req_type_t mem_req_type;
    main_mem_block_addr_t mem_req_block_addr;
    block_data_t mem_req_block_data, mem_resp_block_data;
    logic spurious_resp_err;

    // Fixed-priority instance signals
    logic f_ic_vld, f_ic_rdy, f_ic_rsp_vld;
    main_mem_block_addr_t f_ic_addr;
    block_data_t f_ic_rsp_dat;
    logic f_dc_vld, f_dc_rdy, f_dc_rsp_vld;
    req_type_t f_dc_type;
    main_mem_block_addr_t f_dc_addr;
    block_data_t f_dc_dat, f_dc_rsp_dat;
    logic f_mem_vld, f_mem_rdy, f_mem_rsp_vld;
    req_type_t f_mem_type;
    main_mem_block_addr_t f_mem_addr;
    block_data_t f_mem_dat, f_mem_rsp_dat;
    logic f_spurious;

    logic [4:0] flags, f_flags;
    assign flags   = {icache_req_ready, dcache_req_ready, mem_req_valid, icache_resp_valid, dcache_resp_valid};
    assign f_flags = {f_ic_rdy, f_dc_rdy, f_mem_vld, f_ic_rsp_vld, f_dc_rsp_vld};

    int checks = 0;
    int errors = 0;

    mem_ctrl_arbiter #(.FIXED_DCACHE_PRIO(1'b0)) dut (
        .clk(clk), .rst_aH(rst_aH),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_block_addr(icache_req_block_addr),
        .icache_resp_valid(icache_resp_valid), .icache_resp_block_data(icache_resp_block_data),
        .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
        .dcache_req_type(dcache_req_type), .dcache_req_block_addr(dcache_req_block_addr),
        .dcache_req_block_data(dcache_req_block_data),
        .dcache_resp_valid(dcache_resp_valid), .dcache_resp_block_data(dcache_resp_block_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_type(mem_req_type), .mem_req_block_addr(mem_req_block_addr),
        .mem_req_block_data(mem_req_block_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_block_data(mem_resp_block_data),
        .spurious_resp_err(spurious_resp_err)
    );

    mem_ctrl_arbiter #(.FIXED_DCACHE_PRIO(1'b1)) dut_fixed (
        .clk(clk), .rst_aH(rst_aH),
        .icache_req_valid(f_ic_vld), .icache_req_ready(f_ic_rdy),
        .icache_req_block_addr(f_ic_addr),
        .icache_resp_valid(f_ic_rsp_vld), .icache_resp_block_data(f_ic_rsp_dat),
        .dcache_req_valid(f_dc_vld), .dcache_req_ready(f_dc_rdy),
        .dcache_req_type(f_dc_type), .dcache_req_block_addr(f_dc_addr),
        .dcache_req_block_data(f_dc_dat),
        .dcache_resp_valid(f_dc_rsp_vld), .dcache_resp_block_data(f_dc_rsp_dat),
        .mem_req_valid(f_mem_vld), .mem_req_ready(f_mem_rdy),
        .mem_req_type(f_mem_type), .mem_req_block_addr(f_mem_addr),
        .mem_req_block_data(f_mem_dat),
        .mem_resp_valid(f_mem_rsp_vld), .mem_resp_block_data(f_mem_rsp_dat),
        .spurious_resp_err(f_spurious)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        icache_req_valid = 1'b0; icache_req_block_addr = '0;
        dcache_req_valid = 1'b0; dcache_req_type = REQ_READ;
        dcache_req_block_addr = '0; dcache_req_block_data = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_block_data = '0;
        f_ic_vld = 1'b0; f_ic_addr = '0; f_dc_vld = 1'b0; f_dc_type = REQ_READ;
        f_dc_addr = '0; f_dc_dat = '0; f_mem_rdy = 1'b0; f_mem_rsp_vld = 1'b0; f_mem_rsp_dat = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_aH = 1'b1;
        tick();
        tick();
        rst_aH = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_aH = 1'b1;
        icache_req_valid = 1'b1; dcache_req_valid = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        f_ic_vld = 1'b1; f_dc_vld = 1'b1;
        tick();
        tick();
        settle();
        checks++;
        if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b exp %b", flags, 5'b00000); end
        checks++;
        if (f_flags !== 5'b00000) begin errors++; $display("FAIL reset_flags_fixed: got %b exp %b", f_flags, 5'b00000); end
        checks++;
        if (spurious_resp_err !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b exp 0", spurious_resp_err); end
        checks++;
        if ({mem_req_type, mem_req_block_addr, mem_req_block_data} !== '0) begin
            errors++; $display("FAIL reset_latched: got addr %h data %h", mem_req_block_addr, mem_req_block_data);
        end
        tick();
        clear_inputs();
        rst_aH = 1'b0;
    endtask

    task automatic test_post_reset_tie();
        icache_req_valid = 1'b1; icache_req_block_addr = main_mem_block_addr_t'(8'h10);
        dcache_req_valid = 1'b1; dcache_req_type = REQ_READ; dcache_req_block_addr = main_mem_block_addr_t'(8'h20);
        settle();
        checks++;
        if (flags !== 5'b10000) begin errors++; $display("FAIL tie_first_grant: got %b exp %b", flags, 5'b10000); end
        tick();
        icache_req_valid = 1'b0;
        settle();
        checks++;
        if (flags !== 5'b00100 || mem_req_block_addr !== main_mem_block_addr_t'(8'h10) || mem_req_type !== REQ_READ) begin
            errors++; $display("FAIL tie_mem_req_ic: got flags %b addr %h exp 00100 addr 10", flags, mem_req_block_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_block_data = block_data_t'(16'h1111);
        settle();
        checks++;
        if (flags !== 5'b00010 || icache_resp_block_data !== block_data_t'(16'h1111)) begin
            errors++; $display("FAIL tie_ic_resp: got flags %b data %h exp 00010 data 1111", flags, icache_resp_block_data);
        end
        tick();
        mem_resp_valid = 1'b0;
        settle();
        checks++;
        if (flags !== 5'b01000) begin errors++; $display("FAIL tie_second_grant: got %b exp %b", flags, 5'b01000); end
        tick();
        dcache_req_valid = 1'b0;
        settle();
        checks++;
        if (flags !== 5'b00100 || mem_req_block_addr !== main_mem_block_addr_t'(8'h20)) begin
            errors++; $display("FAIL tie_mem_req_dc: got flags %b addr %h exp 00100 addr 20", flags, mem_req_block_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_block_data = block_data_t'(16'h2222);
        settle();
        checks++;
        if (flags !== 5'b00001 || dcache_resp_block_data !== block_data_t'(16'h2222)) begin
            errors++; $display("FAIL tie_dc_resp: got flags %b data %h exp 00001 data 2222", flags, dcache_resp_block_data);
        end
        tick();
        mem_resp_valid = 1'b0;
    endtask

    // Starts with last grant = dcache, so the alternation begins with icache.
    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            logic [4:0] exp_grant;
            logic [4:0] exp_resp;
            main_mem_block_addr_t exp_addr;
            icache_req_valid = 1'b1; icache_req_block_addr = main_mem_block_addr_t'(12'h100 + k);
            dcache_req_valid = 1'b1; dcache_req_type = REQ_READ; dcache_req_block_addr = main_mem_block_addr_t'(12'h200 + k);
            exp_grant = (k % 2 == 0) ? 5'b10000 : 5'b01000;
            exp_resp  = (k % 2 == 0) ? 5'b00010 : 5'b00001;
            exp_addr  = (k % 2 == 0) ? icache_req_block_addr : dcache_req_block_addr;
            settle();
            checks++;
            if (flags !== exp_grant) begin errors++; $display("FAIL b2b_grant_%0d: got %b exp %b", k, flags, exp_grant); end
            tick();
            settle();
            checks++;
            if (flags !== 5'b00100 || mem_req_block_addr !== exp_addr) begin
                errors++; $display("FAIL b2b_mem_%0d: got flags %b addr %h exp 00100 addr %h", k, flags, mem_req_block_addr, exp_addr);
            end
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_block_data = block_data_t'(k);
            settle();
            checks++;
            if (flags !== exp_resp) begin errors++; $display("FAIL b2b_resp_%0d: got %b exp %b", k, flags, exp_resp); end
            tick();
            mem_resp_valid = 1'b0;
        end
        icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
    endtask

    task automatic test_dcache_write();
        dcache_req_valid = 1'b1; dcache_req_type = REQ_WRITE;
        dcache_req_block_addr = main_mem_block_addr_t'(4'h5); dcache_req_block_data = block_data_t'(16'hA5A5);
        settle();
        checks++;
        if (flags !== 5'b01000) begin errors++; $display("FAIL wr_grant: got %b exp %b", flags, 5'b01000); end
        tick();
        dcache_req_valid = 1'b0; dcache_req_block_data = '0; dcache_req_block_addr = '0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1'b1;
            settle();
            checks++;
            if (flags !== 5'b00100 || mem_req_type !== REQ_WRITE || mem_req_block_addr !== main_mem_block_addr_t'(4'h5)
                || mem_req_block_data !== block_data_t'(16'hA5A5)) begin
                errors++; $display("FAIL wr_stable_%0d: got flags %b type %b addr %h data %h", i, flags, mem_req_type,
                                   mem_req_block_addr, mem_req_block_data);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        icache_req_valid = 1'b1; icache_req_block_addr = main_mem_block_addr_t'(8'h33);
        settle();
        checks++;
        if (flags !== 5'b10000) begin errors++; $display("FAIL wr_idle_after: got %b exp %b", flags, 5'b10000); end
        tick();
        icache_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_read_steering();
        dcache_req_valid = 1'b1; dcache_req_type = REQ_READ; dcache_req_block_addr = main_mem_block_addr_t'(8'h77);
        settle();
        checks++;
        if (flags !== 5'b01000) begin errors++; $display("FAIL rd_grant: got %b exp %b", flags, 5'b01000); end
        tick();
        dcache_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_block_data = block_data_t'(16'hDEAD);
        settle();
        checks++;
        if (flags !== 5'b00001 || dcache_resp_block_data !== block_data_t'(16'hDEAD)
            || icache_resp_block_data !== block_data_t'(16'hDEAD)) begin
            errors++; $display("FAIL rd_steer: got flags %b dc %h ic %h exp 00001 dead", flags, dcache_resp_block_data,
                               icache_resp_block_data);
        end
        tick();
        mem_resp_valid = 1'b0;
        settle();
        checks++;
        if (flags !== 5'b00000) begin errors++; $display("FAIL rd_one_cycle: got %b exp %b", flags, 5'b00000); end
        tick();
    endtask

    task automatic test_spurious();
        mem_resp_valid = 1'b1; mem_req_ready = 1'b1; mem_resp_block_data = block_data_t'(16'hBAD);
        settle();
        checks++;
        if (flags !== 5'b00000 || spurious_resp_err !== 1'b0) begin
            errors++; $display("FAIL spur_drop: got flags %b err %b exp 00000 0", flags, spurious_resp_err);
        end
        tick();
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (spurious_resp_err !== 1'b1) begin errors++; $display("FAIL spur_sticky_%0d: got %b exp 1", i, spurious_resp_err); end
            tick();
        end
        do_reset();
        settle();
        checks++;
        if (spurious_resp_err !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b exp 0", spurious_resp_err); end
        tick();
    endtask

    task automatic test_mid_reset();
        dcache_req_valid = 1'b1; dcache_req_type = REQ_READ; dcache_req_block_addr = main_mem_block_addr_t'(8'h40);
        tick();
        dcache_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_aH = 1'b1; icache_req_valid = 1'b1; icache_req_block_addr = main_mem_block_addr_t'(8'h41);
        settle();
        checks++;
        if (flags !== 5'b00000) begin errors++; $display("FAIL midrst_outputs: got %b exp %b", flags, 5'b00000); end
        tick();
        rst_aH = 1'b0; mem_resp_valid = 1'b1; mem_resp_block_data = block_data_t'(16'h0BAD);
        settle();
        checks++;
        if (flags !== 5'b10000) begin errors++; $display("FAIL midrst_regrant: got %b exp %b", flags, 5'b10000); end
        tick();
        mem_resp_valid = 1'b0; icache_req_valid = 1'b0;
        settle();
        checks++;
        if (spurious_resp_err !== 1'b1 || flags !== 5'b00100 || mem_req_block_addr !== main_mem_block_addr_t'(8'h41)) begin
            errors++; $display("FAIL midrst_late_resp: got err %b flags %b addr %h exp 1 00100 41", spurious_resp_err,
                               flags, mem_req_block_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        settle();
        checks++;
        if (flags !== 5'b00010) begin errors++; $display("FAIL midrst_resp: got %b exp %b", flags, 5'b00010); end
        tick();
        mem_resp_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_fixed_prio();
        for (int k = 0; k < 4; k++) begin
            f_ic_vld = 1'b1; f_ic_addr = main_mem_block_addr_t'(12'h300 + k);
            f_dc_vld = 1'b1; f_dc_type = REQ_READ; f_dc_addr = main_mem_block_addr_t'(12'h400 + k);
            settle();
            checks++;
            if (f_flags !== 5'b01000) begin errors++; $display("FAIL fixed_grant_%0d: got %b exp %b", k, f_flags, 5'b01000); end
            tick();
            settle();
            checks++;
            if (f_mem_addr !== main_mem_block_addr_t'(12'h400 + k)) begin
                errors++; $display("FAIL fixed_addr_%0d: got %h exp %h", k, f_mem_addr, 12'h400 + k);
            end
            f_mem_rdy = 1'b1;
            tick();
            f_mem_rdy = 1'b0; f_mem_rsp_vld = 1'b1;
            tick();
            f_mem_rsp_vld = 1'b0;
        end
        f_ic_vld = 1'b0; f_dc_vld = 1'b0;
    endtask

    // Transaction-level model: a single in-flight slot, grant by tie rule,
    // request presented until accepted, reads complete on the next memory response.
    task automatic test_random();
        bit ic_pend = 0, dc_pend = 0;
        main_mem_block_addr_t ic_a = '0, dc_a = '0;
        req_type_t dc_t = REQ_READ;
        block_data_t dc_d = '0;
        bit busy = 0, sent = 0, cur_dc = 0, last_dc = 1, grant_dc;
        req_type_t cur_t = REQ_READ;
        main_mem_block_addr_t cur_a = '0;
        block_data_t cur_d = '0;
        bit exp_ir, exp_dr, exp_mv, exp_irv, exp_drv;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!ic_pend && $urandom_range(0, 3) == 0) begin
                ic_pend = 1; ic_a = main_mem_block_addr_t'($urandom);
            end else if (ic_pend && $urandom_range(0, 15) == 0) ic_pend = 0;
            if (!dc_pend && $urandom_range(0, 3) == 0) begin
                dc_pend = 1; dc_a = main_mem_block_addr_t'($urandom);
                dc_t = req_type_t'($urandom_range(0, 1)); dc_d = {$urandom, $urandom, $urandom, $urandom};
            end else if (dc_pend && $urandom_range(0, 15) == 0) dc_pend = 0;
            icache_req_valid = ic_pend; icache_req_block_addr = ic_a;
            dcache_req_valid = dc_pend; dcache_req_type = dc_t;
            dcache_req_block_addr = dc_a; dcache_req_block_data = dc_d;
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_resp_valid = busy && sent && ($urandom_range(0, 2) == 0);
            mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
            settle();

            grant_dc = (ic_pend && dc_pend) ? !last_dc : dc_pend;
            exp_ir = !busy && (ic_pend || dc_pend) && !grant_dc;
            exp_dr = !busy && (ic_pend || dc_pend) && grant_dc;
            checks++;
            if ({icache_req_ready, dcache_req_ready} !== {exp_ir, exp_dr}) begin
                errors++; $display("FAIL rnd_ready cyc %0d: got %b%b exp %b%b", cyc, icache_req_ready, dcache_req_ready, exp_ir, exp_dr);
            end
            exp_mv = busy && !sent;
            checks++;
            if (mem_req_valid !== exp_mv) begin errors++; $display("FAIL rnd_mem_vld cyc %0d: got %b exp %b", cyc, mem_req_valid, exp_mv); end
            if (exp_mv) begin
                checks++;
                if (mem_req_type !== cur_t || mem_req_block_addr !== cur_a
                    || (cur_t == REQ_WRITE && mem_req_block_data !== cur_d)) begin
                    errors++; $display("FAIL rnd_mem_req cyc %0d: got %b %h %h exp %b %h %h", cyc, mem_req_type,
                                       mem_req_block_addr, mem_req_block_data, cur_t, cur_a, cur_d);
                end
            end
            exp_irv = busy && sent && mem_resp_valid && !cur_dc;
            exp_drv = busy && sent && mem_resp_valid && cur_dc;
            checks++;
            if ({icache_resp_valid, dcache_resp_valid} !== {exp_irv, exp_drv}
                || icache_resp_block_data !== mem_resp_block_data || dcache_resp_block_data !== mem_resp_block_data) begin
                errors++; $display("FAIL rnd_resp cyc %0d: got %b%b exp %b%b", cyc, icache_resp_valid, dcache_resp_valid, exp_irv, exp_drv);
            end
            checks++;
            if (spurious_resp_err !== 1'b0) begin errors++; $display("FAIL rnd_spurious cyc %0d: got %b exp 0", cyc, spurious_resp_err); end

            if (exp_ir || exp_dr) begin
                busy = 1; sent = 0; cur_dc = grant_dc; last_dc = grant_dc;
                cur_t = grant_dc ? dc_t : REQ_READ;
                cur_a = grant_dc ? dc_a : ic_a;
                cur_d = grant_dc ? dc_d : '0;
                if (grant_dc) dc_pend = 0; else ic_pend = 0;
            end else if (busy && !sent && mem_req_ready) begin
                if (cur_t == REQ_WRITE) busy = 0; else sent = 1;
            end else if (busy && sent && mem_resp_valid) begin
                busy = 0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst_aH = 1'b1;
        clear_inputs();
        test_reset();
        test_post_reset_tie();
        test_back_to_back();
        test_dcache_write();
        test_read_steering();
        test_spurious();
        test_mid_reset();
        test_fixed_prio();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
